// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the cache-side memory request/response bus.
package sys_defs;
    localparam int XLEN         = 32;
    localparam int MEM_TAG_W    = 4;
    localparam int NUM_MEM_TAGS = 15;
    localparam int LINE_W       = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

// File: rtl/mem_responder_tag_alloc.sv
// Busy mask for transaction tags 1..15 with a lowest-free priority encoder.
module mem_tag_allocator
    import sys_defs::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set,
    input  logic [MEM_TAG_W-1:0] set_tag,
    input  logic                 clear,
    input  logic [MEM_TAG_W-1:0] clear_tag,
    output logic [MEM_TAG_W-1:0] free_tag,
    output logic                 any_free
);
    logic [NUM_MEM_TAGS:1] busy;

    // Scan downward so the last hit is the lowest free tag.
    always_comb begin
        free_tag = '0;
        any_free = 1'b0;
        for (int t = NUM_MEM_TAGS; t >= 1; t--) begin
            if (!busy[t]) begin
                free_tag = MEM_TAG_W'(t);
                any_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int t = 1; t <= NUM_MEM_TAGS; t++) begin
                if (set && set_tag == MEM_TAG_W'(t))
                    busy[t] <= 1'b1;
                else if (clear && clear_tag == MEM_TAG_W'(t))
                    busy[t] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Tagged memory responder: same-cycle tag allocation, fixed-latency load return.
module mem_responder
    import sys_defs::*;
#(
    parameter int LATENCY   = 8,
    parameter int MEM_LINES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  BUS_COMMAND           proc2mem_command,
    input  logic [XLEN-1:0]      proc2mem_addr,
    input  logic [LINE_W-1:0]    proc2mem_data,
    input  logic                 load_en,
    input  logic [XLEN-1:0]      load_addr,
    input  logic [LINE_W-1:0]    load_data,
    output logic [MEM_TAG_W-1:0] mem2proc_response,
    output logic                 mem2proc_response_valid,
    output logic [LINE_W-1:0]    mem2proc_data,
    output logic [MEM_TAG_W-1:0] mem2proc_tag
);
    localparam int              IDX_W      = $clog2(MEM_LINES);
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(8 * MEM_LINES);

    logic [LINE_W-1:0] mem [MEM_LINES];

    logic [IDX_W-1:0]     cmd_idx, bd_idx;
    logic                 cmd_in_range, bd_in_range;
    logic                 accept, load_go, store_go;
    logic [MEM_TAG_W-1:0] free_tag;
    logic                 any_free;

    logic [LATENCY-1:0]   vld_pipe;
    logic [MEM_TAG_W-1:0] tag_pipe  [LATENCY];
    logic [LINE_W-1:0]    data_pipe [LATENCY];

    assign cmd_idx      = proc2mem_addr[3 +: IDX_W];
    assign bd_idx       = load_addr[3 +: IDX_W];
    assign cmd_in_range = proc2mem_addr < ADDR_LIMIT;
    assign bd_in_range  = load_addr < ADDR_LIMIT;

    // A backdoor write owns the storage this cycle, so bus traffic is refused.
    assign accept   = (proc2mem_command != BUS_NONE) && cmd_in_range && any_free && !load_en;
    assign load_go  = accept && (proc2mem_command == BUS_LOAD);
    assign store_go = accept && (proc2mem_command == BUS_STORE);

    assign mem2proc_response       = accept ? free_tag : '0;
    assign mem2proc_response_valid = proc2mem_command != BUS_NONE;

    mem_tag_allocator u_alloc (
        .clock    (clock),
        .reset    (reset),
        .set      (load_go),
        .set_tag  (free_tag),
        .clear    (vld_pipe[LATENCY-1]),
        .clear_tag(tag_pipe[LATENCY-1]),
        .free_tag (free_tag),
        .any_free (any_free)
    );

    always_ff @(posedge clock) begin
        if (store_go)
            mem[cmd_idx] <= proc2mem_data;
        if (load_en && bd_in_range)
            mem[bd_idx] <= load_data;
    end

    // Empty slots carry zero tag/data so the last stage drives the outputs directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i]  <= '0;
                data_pipe[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                tag_pipe[i]  <= tag_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
            vld_pipe[0]  <= load_go;
            tag_pipe[0]  <= load_go ? free_tag : '0;
            data_pipe[0] <= load_go ? mem[cmd_idx] : '0;
        end
    end

    assign mem2proc_tag  = tag_pipe[LATENCY-1];
    assign mem2proc_data = data_pipe[LATENCY-1];
endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable memory-side responder for the tagged request/response bus that the instruction and data caches drive as initiators. It accepts one load or store command per cycle and answers in the same cycle with a 4-bit transaction tag, or 0 to reject. Each accepted load returns its 64-bit line exactly `LATENCY` cycles later, marked with its tag. It replaces the behavioural memory in cache-level benches and sits between the cache arbiter and the backing store.

## Interface
- `LATENCY`, default 8: cycles from load acceptance to data return; legal range 1..32.
- `MEM_LINES`, default 1024: number of 64-bit lines in the backing store; must be a power of two.
- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clock`.
- `proc2mem_command` in `BUS_COMMAND`: `BUS_NONE`, `BUS_LOAD` or `BUS_STORE`.
- `proc2mem_addr` in `XLEN`: byte address; bits [2:0] are ignored.
- `proc2mem_data` in 64: store data.
- `load_en` in 1: backdoor preload strobe.
- `load_addr` in `XLEN`: backdoor byte address.
- `load_data` in 64: backdoor line data.
- `mem2proc_response` out 4: allocated tag, or 0 for reject.
- `mem2proc_response_valid` out 1: high exactly when `proc2mem_command != BUS_NONE`.
- `mem2proc_data` out 64: returned line.
- `mem2proc_tag` out 4: tag of the returning line; 0 when no return this cycle.

## Operation
- **Line index.** Index = `addr[3 +: $clog2(MEM_LINES)]`.
  - Out of range when `addr >= 8*MEM_LINES`.
- **Tag pool.** Tags 1..15 are held in a busy mask.
  - Allocation picks the lowest-numbered free tag.
- **Rejection.** `response = 0` when any of these hold:
  - out-of-range address;
  - no free tag;
  - `load_en` high.
- **BUS_NONE.** `response = 0` and `response_valid = 0`.
- **Accepted BUS_LOAD.**
  - Allocated tag marked busy at the clock edge.
  - Line data snapshotted at acceptance.
  - Tag and data pushed into a `LATENCY`-deep return pipeline.
- **Accepted BUS_STORE.**
  - `response` = lowest free tag; the tag is not marked busy.
  - Line written at the clock edge.
  - No data return.
- **Return.** When a pipeline entry reaches the output stage:
  - `mem2proc_tag` and `mem2proc_data` are driven from registers for exactly one cycle.
  - The tag's busy bit clears at the end of that cycle.
  - A returning tag is not allocatable during its return cycle; it is allocatable from the next cycle.
- **Idle output.** With no return, `mem2proc_tag = 0` and `mem2proc_data = 0`.
- **Ordering.** Returns stay in acceptance order; at most one return per cycle.
- **Store/load order.** A store followed by a load of the same line returns the new data. A load followed by a store returns the old data.
- **Backdoor load.** `load_en` writes `load_data` at the edge if `load_addr` is in range; an out-of-range `load_addr` is ignored.
- **Reset.**
  - Busy mask cleared; pipeline valids cleared.
  - In-flight loads are dropped; no stale tag appears after reset.
  - Storage contents are retained, not reset.

## Timing
- `mem2proc_response` and `mem2proc_response_valid` are combinational from command, address, `load_en` and busy mask, in the same cycle as the command.
- A load accepted in cycle T returns in cycle T+`LATENCY`.
- Reset values: `mem2proc_tag = 0`, `mem2proc_data = 0`. Response outputs follow their combinational definition; with `BUS_NONE` applied, both are 0.
- **Sustained loads.** Throughput is 1 per cycle while tags are free. With `LATENCY > 15`, the 16th consecutive load is rejected until the first return frees a tag.
- **Reset mid-operation.** Reset asserted in cycle R suppresses every return in R+1 onward. The first request after reset gets tag 1.

## Structure
- **Shared package (`sys_defs`):**
  - `BUS_COMMAND` enum;
  - `MEM_TAG_W = 4`;
  - `NUM_MEM_TAGS = 15`;
  - the line-data width of 64.
- **Sub-module `mem_tag_allocator`:**
  - free-mask priority encoder;
  - returns the lowest free tag and an `any_free` flag;
  - takes `set` and `clear` strobes.
- **Top level:** storage array, return pipeline and response logic.

## Test plan
- **Basic load.** Preload line 0x10 = 0xDEADBEEF_01234567, then `BUS_LOAD` 0x84 at T → at T: response 1, valid 1. At T+8: tag 1, data 0xDEADBEEF_01234567 for one cycle; tag 0 at T+9.
- **Tag exhaustion (LATENCY = 20).** 16 back-to-back loads → tags 1..15, 16th gets response 0. Tag 1 is returned at T+20 and not reused in that cycle; a load at T+21 gets tag 1.
- **Store/load ordering.**
  - STORE 0x40 data 0xA5A5 at T, LOAD 0x40 at T+1 → returns 0xA5A5 at T+1+`LATENCY`.
  - LOAD 0x40 then STORE 0x40 with 0x1 on the next cycle → the load returns 0xA5A5.
- **Out-of-range address.** LOAD at 8*`MEM_LINES` → response 0, valid 1, no return. `load_en` high with a LOAD → response 0.
- **Reset mid-flight.** Reset at T+3 during a pending load → `mem2proc_tag` stays 0 through T+`LATENCY`+2; the next LOAD gets tag 1.
- **Idle bus.** `BUS_NONE` for 10 cycles → response 0, valid 0, tag 0 throughout.
